timer: RTL and testbench
========================

TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  2 (bits [3:2])  register select: 0=CTRL, 1=PRESET, 2=COUNT, 3=ACK
- we  in  1  write strobe, sampled on the rising edge of clk
- din  in  32  write data
- dout  out  32  combinational read data for addr
- irq  out  1  interrupt request; drives one HWInt line of the coprocessor
REQ-002 CTRL SHALL hold these fields; all other bits SHALL read 0:
- [0] EN, count enable
- [2:1] MODE: 00 = one-shot, 01 = auto-reload; 1x SHALL behave as 00
- [3] IM, interrupt mask (1 = enabled)

Function
REQ-003 dout SHALL return:
- addr 0: {28'b0, CTRL[3:0]}
- addr 1: PRESET
- addr 2: COUNT
- addr 3: {31'b0, PEND}
REQ-004 Writes to addr 2 SHALL be ignored; COUNT is read-only.
REQ-005 irq SHALL equal PEND & IM, combinationally.
REQ-006 The FSM SHALL have the states IDLE, LOAD, CNT and INT.
REQ-007 IDLE -> LOAD when EN=1; otherwise IDLE holds and COUNT holds its value.
REQ-008 LOAD SHALL copy PRESET into COUNT and go to CNT, taking one cycle.
REQ-009 In CNT with EN=0, the FSM SHALL go to IDLE and COUNT SHALL hold.
REQ-010 In CNT with EN=1 and COUNT>1, COUNT SHALL decrement by 1 per cycle.
REQ-011 In CNT with EN=1 and COUNT<=1, COUNT SHALL become 0, PEND SHALL be set on the same edge, and the FSM SHALL go to INT.
REQ-012 INT SHALL last one cycle.
- MODE=00: EN is cleared, then IDLE.
- MODE=01: LOAD.
REQ-013 Auto-reload period with PRESET=N SHALL be N+2 cycles (LOAD, N CNT cycles, INT); with N=0, 2 cycles.
REQ-014 A PRESET write during CNT SHALL NOT affect the current count; it takes effect at the next LOAD.
REQ-015 Writing EN=1 while the FSM is in CNT SHALL NOT restart the count; a restart requires EN=0 and then EN=1.
REQ-016 Arithmetic is unsigned 32-bit; COUNT SHALL never wrap below 0.
REQ-017 If a PEND-clearing write and a PEND set occur on the same edge, the set SHALL win and no interrupt is lost.
REQ-018 If a CTRL write occurs on the same edge as an INT exit in MODE=00, the written CTRL SHALL win, including EN.

Reset
REQ-019 When rst=0, asynchronously:
- CTRL=0, PRESET=0, COUNT=0, PEND=0
- state IDLE, irq=0
REQ-020 Reset asserted mid-count SHALL abort the count and drop irq immediately, with no synchronisation to clk.

Configuration
REQ-021 Macro TIMER_IRQ_ACK_EN SHALL control interrupt clearing.
REQ-022 With TIMER_IRQ_ACK_EN defined:
- PEND is sticky in both modes.
- PEND is cleared only by a write to addr 3 (din ignored).
- Writes to CTRL do not clear PEND.
REQ-023 With TIMER_IRQ_ACK_EN undefined:
- MODE=00: PEND is cleared by any CTRL write.
- MODE=01: PEND is cleared on the edge leaving INT, giving a 1-cycle irq pulse.
- Writes to addr 3 are ignored.
- addr 3 reads PEND.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- One-shot: PRESET=3, CTRL=0x9 (EN, IM) written at edge E0 -> E1 LOAD; COUNT=3,2,1,0 at E2..E5; irq=1 after E5; EN=0 after E6; irq held until CTRL write (macro undefined).
- Auto-reload: PRESET=2, CTRL=0xB -> irq pulses 1 cycle every 4 cycles (macro undefined); COUNT sequence 2,1,0,2,1,0.
- Mask: PRESET=1, CTRL=0x1 (IM=0) -> PEND read at addr 3 = 1 and irq=0; then write CTRL=0x8 -> irq stays 0 because that CTRL write clears PEND.
- Pause: clear EN when COUNT=5 -> COUNT holds 5 in IDLE; re-enable -> LOAD restarts from PRESET.
- Macro defined, auto-reload PRESET=0: irq rises and stays 1 across reloads until an addr 3 write; an ack on the same edge as a terminal count leaves irq=1.
- Reset with rst=0 mid-CNT at COUNT=7 -> COUNT=0, CTRL=0, irq=0 before the next clk edge.

Source files
------------

// File: rtl/timer.sv
// timer: programmable down-counter with one-shot/auto-reload modes and a maskable interrupt.
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous active-low reset
//   addr  - register select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=ACK
//   we    - write strobe
//   din   - write data
//   dout  - combinational read data for addr
//   irq   - interrupt request, PEND & IM
// Build option: define TIMER_IRQ_ACK_EN to make PEND sticky until a write to addr 3.
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:2]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;
    logic        en;
    logic        auto_reload;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        pend_set;
    logic        pend_clr;
    assign en          = ctrl[0];
    assign auto_reload = ctrl[2:1] == 2'b01;
    assign wr_ctrl     = we && addr == 2'd0;
    assign wr_preset   = we && addr == 2'd1;
    // A zero preset skips CNT entirely so the reload period stays at two cycles.
    assign pend_set    = (state == CNT && en && count <= 32'd1) || (state == LOAD && preset == 32'd0);
`ifdef TIMER_IRQ_ACK_EN
    assign pend_clr    = we && addr == 2'd3;
`else
    assign pend_clr    = (wr_ctrl && !auto_reload) || (state == INT && auto_reload);
`endif
    assign irq         = pend & ctrl[3];
    always_comb
        dout = addr == 2'd0 ? {28'b0, ctrl} :
               addr == 2'd1 ? preset :
               addr == 2'd2 ? count : {31'b0, pend};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ctrl   <= 4'b0;
            preset <= 32'b0;
            count  <= 32'b0;
            pend   <= 1'b0;
        end else begin
            if (wr_preset) preset <= din;
            // Set has priority over clear so a terminal count is never lost.
            pend <= pend_set | (pend & ~pend_clr);
            // A CTRL write beats the one-shot EN clear on the INT exit edge.
            if (wr_ctrl) ctrl <= din[3:0];
            else if (state == INT && !auto_reload) ctrl[0] <= 1'b0;
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= preset == 32'd0 ? INT : CNT;
                end
                CNT: begin
                    if (!en) state <= IDLE;
                    else if (count > 32'd1) count <= count - 32'd1;
                    else begin
                        count <= 32'd0;
                        state <= INT;
                    end
                end
                INT: state <= auto_reload ? LOAD : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer.sv
// tb_timer: directed table-driven bench for timer, plus hand-written reset sequences.
module tb_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] xd;
        logic        xi;
    } vec_t;
    vec_t tv[$];

    timer dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .we(we),
        .din(din),
        .dout(dout),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic add(input logic w, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] xd, input logic xi);
        tv.push_back('{w, a, d, xd, xi});
    endtask

    // One clock per step: drive, cross one rising edge, sample at the falling edge.
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
        we = w;
        addr = a;
        din = d;
        @(negedge clk);
        we = 1'b0;
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].w, tv[i].a, tv[i].d);
            chk($sformatf("%s row%0d dout", tag, i), dout, tv[i].xd);
            chk($sformatf("%s row%0d irq", tag, i), {31'b0, irq}, {31'b0, tv[i].xi});
        end
        tv.delete();
    endtask

    initial begin
        #2;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            chk($sformatf("reset dout a%0d", a), dout, 32'd0);
        end
        chk("reset irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`ifdef TIMER_IRQ_ACK_EN
        add(1, 1, 0, 0, 0);
        add(1, 0, 32'hB, 32'hB, 0);
        add(0, 3, 0, 0, 0);
        add(0, 3, 0, 1, 1);
        add(0, 3, 0, 1, 1);
        add(0, 3, 0, 1, 1);
        add(1, 3, 0, 0, 0);
        add(1, 3, 0, 1, 1);
        add(0, 3, 0, 1, 1);
        add(1, 0, 32'h9, 32'h9, 1);
        add(1, 3, 0, 0, 0);
        add(0, 0, 0, 32'h8, 0);
        run_table("ack");
`else
        add(1, 1, 3, 3, 0);
        add(1, 0, 32'h9, 32'h9, 0);
        add(0, 2, 0, 0, 0);
        add(0, 2, 0, 3, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 1, 0);
        add(0, 2, 0, 0, 1);
        add(0, 0, 0, 32'h8, 1);
        add(0, 3, 0, 1, 1);
        add(0, 2, 0, 0, 1);
        add(1, 0, 32'h8, 32'h8, 0);
        add(1, 0, 0, 0, 0);
        run_table("oneshot");
        add(1, 1, 2, 2, 0);
        add(1, 0, 32'hB, 32'hB, 0);
        add(0, 2, 0, 0, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 1, 0);
        add(0, 2, 0, 0, 1);
        add(0, 2, 0, 0, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 1, 0);
        add(0, 2, 0, 0, 1);
        add(0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        add(0, 2, 0, 2, 0);
        add(1, 2, 32'h55, 2, 0);
        run_table("reload");
        add(1, 1, 1, 1, 0);
        add(1, 0, 1, 1, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 1, 0);
        add(0, 3, 0, 1, 0);
        add(0, 0, 0, 0, 0);
        add(0, 3, 0, 1, 0);
        add(1, 0, 32'h8, 32'h8, 0);
        add(0, 3, 0, 0, 0);
        add(1, 3, 1, 0, 0);
        add(1, 0, 32'hFFFF_FFF0, 0, 0);
        run_table("mask");
        add(1, 1, 8, 8, 0);
        add(1, 0, 1, 1, 0);
        add(0, 2, 0, 0, 0);
        add(0, 2, 0, 8, 0);
        add(0, 2, 0, 7, 0);
        add(0, 2, 0, 6, 0);
        add(1, 0, 0, 0, 0);
        add(0, 2, 0, 5, 0);
        add(0, 2, 0, 5, 0);
        add(1, 0, 1, 1, 0);
        add(0, 2, 0, 5, 0);
        add(0, 2, 0, 8, 0);
        add(0, 2, 0, 7, 0);
        add(1, 1, 3, 3, 0);
        add(0, 2, 0, 5, 0);
        add(1, 0, 1, 1, 0);
        add(0, 2, 0, 3, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 1, 0);
        add(0, 2, 0, 0, 0);
        add(1, 0, 1, 1, 0);
        add(0, 2, 0, 0, 0);
        add(0, 2, 0, 3, 0);
        add(1, 0, 0, 0, 0);
        add(0, 2, 0, 2, 0);
        add(0, 2, 0, 2, 0);
        run_table("pause");
`endif
        step(1, 1, 20);
        step(1, 0, 32'h9);
        repeat (15) step(0, 2, 0);
        chk("mid count", dout, 32'd7);
        rst = 1'b0;
        #1;
        chk("async count", dout, 32'd0);
        addr = 2'd0;
        #1;
        chk("async ctrl", dout, 32'd0);
        chk("async irq", {31'b0, irq}, 32'd0);
        #1;
        rst = 1'b1;
        repeat (3) step(0, 2, 0);
        chk("post reset idle", dout, 32'd0);
        step(1, 1, 1);
        step(1, 0, 32'h9);
        repeat (4) step(0, 2, 0);
        chk("irq held", {31'b0, irq}, 32'd1);
        rst = 1'b0;
        #1;
        chk("irq drop", {31'b0, irq}, 32'd0);
        rst = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
